data_sram_responder: RTL

//  Target side of the CPU data_sram interface: accepts en/we/addr/wdata from MEM stage, returns rdata.

---
 rtl/data_sram_responder_pkg.sv | 30 +++
 rtl/data_sram_responder_sram_be_ram.sv | 31 +++
 rtl/data_sram_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared constants, read-source select type and byte-lane merge helper
// for the data_sram target (RAM plus MMIO window).
package data_sram_responder_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hbfaf_0000;

  localparam logic [15:0] MMIO_TIMER_OFS   = 16'h0000;
  localparam logic [15:0] MMIO_LED_OFS     = 16'h0004;
  localparam logic [15:0] MMIO_SW_OFS      = 16'h0008;
  localparam logic [15:0] MMIO_SCRATCH_OFS = 16'h000c;

  // Which source drives rdata in the cycle after a read request.
  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_RAM,
    SEL_MMIO
  } rd_sel_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_sram_be_ram.sv
// Single-port word RAM with per-byte write enables and a registered read
// port; the read register only moves on a read so it holds between reads.
module sram_be_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i == 4'b0000) begin
        rdata_q <= mem[addr_i];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// CPU data_sram target: word RAM plus MMIO window (timer, LED, switches,
// scratch) with a fixed one-cycle read latency.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_ADDR_W = 14,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int          LED_W      = 16,
  parameter int          SW_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_we,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  input  logic [SW_W-1:0]  switch_in,
  output logic [LED_W-1:0] led_out,
  output logic [31:0]      timer_out
);

  logic            is_mmio, rd_req, wr_req, ram_en;
  logic [15:0]     mmio_ofs;
  logic [31:0]     ram_rdata, mmio_rdata;

  logic [31:0]     timer_q, timer_d;
  logic [31:0]     scratch_q, scratch_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;
  logic [31:0]     mmio_rdata_q;
  rd_sel_e         sel_q;

  assign is_mmio  = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign mmio_ofs = data_sram_addr[15:0];
  assign rd_req   = data_sram_en & (data_sram_we == 4'b0000) & ~reset;
  assign wr_req   = data_sram_en & (data_sram_we != 4'b0000) & ~reset;
  assign ram_en   = data_sram_en & ~is_mmio & ~reset;

  sram_be_ram #(
    .ADDR_W(RAM_ADDR_W)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (data_sram_we),
    .addr_i (data_sram_addr[RAM_ADDR_W+1:2]),
    .wdata_i(data_sram_wdata),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_ofs)
      MMIO_TIMER_OFS:   mmio_rdata = timer_q;
      MMIO_LED_OFS:     mmio_rdata = {{(32-LED_W){1'b0}}, led_q};
      MMIO_SW_OFS:      mmio_rdata = {{(32-SW_W){1'b0}}, sw_sync_q};
      MMIO_SCRATCH_OFS: mmio_rdata = scratch_q;
      default:          mmio_rdata = 32'h0;
    endcase
  end

  // A timer write replaces that cycle's increment.
  always_comb begin
    timer_d   = timer_q + 32'd1;
    scratch_d = scratch_q;
    led_d     = led_q;
    if (wr_req && is_mmio) begin
      case (mmio_ofs)
        MMIO_TIMER_OFS:   timer_d   = merge_bytes(timer_q, data_sram_wdata, data_sram_we);
        MMIO_SCRATCH_OFS: scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_we);
        MMIO_LED_OFS: begin
          for (int i = 0; i < LED_W; i++) begin
            if (data_sram_we[i/8]) led_d[i] = data_sram_wdata[i];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q      <= 32'h0;
      scratch_q    <= 32'h0;
      led_q        <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      mmio_rdata_q <= 32'h0;
      sel_q        <= SEL_ZERO;
    end else begin
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      led_q     <= led_d;
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
      if (rd_req) begin
        sel_q        <= is_mmio ? SEL_MMIO : SEL_RAM;
        mmio_rdata_q <= mmio_rdata;
      end
    end
  end

  // Select by the registered decode of the request, not the live address.
  always_comb begin
    data_sram_rdata = 32'h0;
    case (sel_q)
      SEL_RAM:  data_sram_rdata = ram_rdata;
      SEL_MMIO: data_sram_rdata = mmio_rdata_q;
      default:  data_sram_rdata = 32'h0;
    endcase
  end

  assign led_out   = led_q;
  assign timer_out = timer_q;

endmodule
